// File: rtl/regfile_write_arbiter.sv
// Purpose: owns the single register-file write port; runs a post-reset init sweep, then arbitrates WB (fixed priority) vs LLU (valid/ready).
// Latency: a request in cycle N drives RegWrite/writeReg/writeData after edge N, so the register file commits at edge N+1.
// Backpressure: WB is never stalled here. The LLU sees llu_ready low while WB writes, and pipe_stall rises once the LLU has been blocked STARVE_LIMIT cycles in a row.
module regfile_write_arbiter #(
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
  parameter bit          DO_INIT      = 1'b1,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        llu_valid,
  input  logic [4:0]  llu_waddr,
  input  logic [31:0] llu_wdata,
  output logic        llu_ready,
  output logic        RegWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        init_busy,
  output logic        pipe_stall
);

  localparam logic       ST_INIT    = 1'b0;
  localparam logic       ST_RUN     = 1'b1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic       state;
  logic [4:0] initCnt;
  logic [3:0] starveCnt;
  logic       wbActive;
  logic       lluXfer;
  logic       lluBlocked;

  // A WB write to $0 counts as no request, so it never takes the port away from the LLU.
  // llu_ready is gated by RST_N so it stays low for the whole reset period.
  always_comb begin
    wbActive   = wb_we && (wb_waddr != 5'd0);
    llu_ready  = RST_N && (state == ST_RUN) && !wbActive;
    lluXfer    = llu_valid && llu_ready;
    lluBlocked = (state == ST_RUN) && llu_valid && !llu_ready;
  end

  // Write-port datapath, init sweep sequencing and stall/busy flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_INIT;
      initCnt    <= 5'd0;
      RegWrite   <= 1'b0;
      writeReg   <= 5'd0;
      writeData  <= 32'd0;
      init_busy  <= 1'b1;
      pipe_stall <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (DO_INIT) begin
            RegWrite  <= 1'b1;
            writeReg  <= initCnt;
            writeData <= INIT_VALUE;
            initCnt   <= initCnt + 5'd1;
            if (initCnt == 5'd31) begin
              init_busy  <= 1'b0;
              pipe_stall <= 1'b0;
              state      <= ST_RUN;
            end
          end else begin
            RegWrite   <= 1'b0;
            init_busy  <= 1'b0;
            pipe_stall <= 1'b0;
            state      <= ST_RUN;
          end
        end
        default: begin
          if (wbActive) begin
            RegWrite  <= 1'b1;
            writeReg  <= wb_waddr;
            writeData <= wb_wdata;
          end else if (lluXfer && (llu_waddr != 5'd0)) begin
            RegWrite  <= 1'b1;
            writeReg  <= llu_waddr;
            writeData <= llu_wdata;
          end else begin
            // An LLU write to $0 still completes its handshake; its data is dropped here.
            RegWrite <= 1'b0;
          end
          // Raise the stall on the edge the starve counter reaches its limit.
          // Once saturated, the +1 no longer matches, so the stall simply holds.
          if (lluXfer) begin
            pipe_stall <= 1'b0;
          end else if (lluBlocked && ((starveCnt + 4'd1) == STARVE_MAX)) begin
            pipe_stall <= 1'b1;
          end
        end
      endcase
    end
  end

  // Count consecutive blocked LLU cycles, saturating at the limit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starveCnt <= 4'd0;
    end else if (!lluBlocked) begin
      starveCnt <= 4'd0;
    end else if (starveCnt != STARVE_MAX) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

endmodule
